sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO: the successor to the fixed 8x16 buffer.
- Generalised data width and depth; two selectable read modes (registered read or first-word-fall-through).
- Adds almost-full/almost-empty thresholds, an occupancy count, protected pointers, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of the data word in bits.
- ADDR_WIDTH, 4, pointer width; depth DEPTH = 2**ADDR_WIDTH, so 16 by default.
- AFULL_THRESH, 12, almost_full asserts when count >= this value (range 1..DEPTH).
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value (range 0..DEPTH-1).
- FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (pop).
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data holds a valid popped word (FWFT=0) or head word (FWFT=1).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- clr_err  in  1  synchronous clear of the sticky error flags.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (asynchronous, immediate):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Resulting outputs: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words; the first post-reset write lands at address 0.
- Acceptance:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - Rejected requests have no effect on pointers, count or memory.
- Pointers:
  - wr_ptr increments by 1 on wr_acc; rd_ptr increments by 1 on rd_acc.
  - Both wrap from DEPTH-1 to 0 naturally (modulo 2**ADDR_WIDTH).
- Count update:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - Flags are combinational decodes of the registered count; they change on the clock edge after the accepting cycle.
- Simultaneous events:
  - Both requests while full: read accepted, write rejected; count goes DEPTH-1 and overflow sets.
  - Both requests while empty: write accepted, read rejected; count goes to 1 and underflow sets.
  - Both requests otherwise: both accepted, count unchanged, data order preserved.
- FWFT=0 (registered read):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the same edge; 1-cycle latency from rd_en.
  - rd_valid <= 0 on any cycle without rd_acc.
  - rd_data holds its last value when no read is accepted.
- FWFT=1 (fall-through):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
  - A word written into an empty FIFO appears on rd_data the cycle after its write edge.
  - rd_en with rd_valid high consumes the displayed word at the edge.
- Error flags:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both hold until clr_err is sampled high.
  - If set and clr_err occur in the same cycle, set wins.
- Threshold edge cases:
  - AFULL_THRESH = DEPTH makes almost_full equivalent to full.
  - AEMPTY_THRESH = 0 makes almost_empty equivalent to empty.

Test Plan:
1. Fill/drain (FWFT=0, defaults):
   - Stimulus: after reset, write 0x01..0x10 on 16 consecutive cycles.
   - Required: full = 1 and count = 16; almost_full first high when count = 12.
   - Then read 16 times: rd_data = 0x01..0x10 in order, each with rd_valid one cycle after rd_en; empty = 1 at the end.
2. Overflow/underflow:
   - Stimulus: one extra write while full; one extra read while empty.
   - Required: count unchanged, overflow = 1, underflow = 1, no data corruption.
   - Then pulse clr_err: both flags go to 0.
   - clr_err coincident with a new illegal write: overflow stays 1.
3. Simultaneous read+write:
   - At count = 5, assert both for 20 cycles: count stays 5, pointers wrap past 15, output order matches input order.
   - When full, assert both: count goes to 15, overflow = 1.
   - When empty, assert both: count goes to 1, underflow = 1.
4. FWFT=1:
   - Write 0xA5 into an empty FIFO: next cycle rd_data = 0xA5 and rd_valid = 1 without rd_en.
   - Pop it: empty = 1, rd_valid = 0.
5. Asynchronous reset:
   - Assert rst mid-stream at count = 9, between clock edges.
   - Required: count = 0, empty = 1, rd_valid = 0 immediately.
   - Next write of 0x3C is the next word read out.
6. Parameter sweep (DATA_WIDTH = 32, ADDR_WIDTH = 3, AFULL_THRESH = 8, AEMPTY_THRESH = 0):
   - Required: full and almost_full assert together at count = 8.
   - almost_empty equals empty throughout.
   - 32-bit patterns such as 0xDEADBEEF come out intact.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered or fall-through read port,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter bit FWFT          = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags decode the registered count only, so they move one edge after acceptance.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    // A request is only honoured when the FIFO can service it; rejected
    // requests leave pointers, count and memory untouched.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky errors: a fresh set outranks a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en & full)  | (overflow  & ~clr_err);
            underflow <= (rd_en & empty) | (underflow & ~clr_err);
        end
    end

    generate
        if (FWFT == 1'b0) begin : g_reg_read
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    if (rd_acc)
                        rd_data <= mem[rd_ptr];
                    rd_valid <= rd_acc;
                end
            end
        end else begin : g_fwft_read
            // Head word is always on display; a pop simply advances rd_ptr.
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = ~empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered-read, fall-through and a
// wide/shallow configuration, checked against a queue-based scoreboard.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: defaults, registered read
    logic       a_wr_en, a_rd_en, a_clr;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [4:0] a_count;

    // Instance F: defaults, fall-through
    logic       f_wr_en, f_rd_en, f_clr;
    logic [7:0] f_wr_data, f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] f_count;

    // Instance W: 32-bit x 8, AFULL=8, AEMPTY=0
    logic        w_wr_en, w_rd_en, w_clr;
    logic [31:0] w_wr_data, w_rd_data;
    logic        w_rd_valid, w_full, w_empty, w_af, w_ae, w_ovf, w_udf;
    logic [3:0]  w_count;

    sync_fifo_param #(.FWFT(1'b0)) u_a (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count), .clr_err(a_clr),
        .overflow(a_ovf), .underflow(a_udf));

    sync_fifo_param #(.FWFT(1'b1)) u_f (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .clr_err(f_clr),
        .overflow(f_ovf), .underflow(f_udf));

    sync_fifo_param #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .AFULL_THRESH(8),
                      .AEMPTY_THRESH(0), .FWFT(1'b0)) u_w (
        .clk(clk), .rst(rst), .wr_en(w_wr_en), .wr_data(w_wr_data), .rd_en(w_rd_en),
        .rd_data(w_rd_data), .rd_valid(w_rd_valid), .full(w_full), .empty(w_empty),
        .almost_full(w_af), .almost_empty(w_ae), .count(w_count), .clr_err(w_clr),
        .overflow(w_ovf), .underflow(w_udf));

    // Reference state for instance A
    int         m_cnt;
    bit         m_ovf, m_udf;
    logic [7:0] sb_a [$];
    logic [31:0] sb_w [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of instance A; inputs applied just after an edge, results
    // checked just after the next edge against the reference model.
    task automatic step_a(input logic we, input logic [7:0] wd, input logic re, input logic ce);
        logic       wacc, racc;
        logic [7:0] exp_d;
        int         old_cnt;
        exp_d = '0;
        a_wr_en = we; a_wr_data = wd; a_rd_en = re; a_clr = ce;
        old_cnt = m_cnt;
        wacc = we && (old_cnt != 16);
        racc = re && (old_cnt != 0);
        if (racc) exp_d = sb_a.pop_front();
        if (wacc) sb_a.push_back(wd);
        m_cnt = old_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
        m_ovf = (we && old_cnt == 16) || (m_ovf && !ce);
        m_udf = (re && old_cnt == 0)  || (m_udf && !ce);
        @(posedge clk); #1;
        a_wr_en = 1'b0; a_rd_en = 1'b0; a_clr = 1'b0;
        chk("a_count", 64'(a_count), 64'(m_cnt));
        chk("a_full",  64'(a_full),  64'(m_cnt == 16));
        chk("a_empty", 64'(a_empty), 64'(m_cnt == 0));
        chk("a_afull", 64'(a_af),    64'(m_cnt >= 12));
        chk("a_aempty",64'(a_ae),    64'(m_cnt <= 4));
        chk("a_ovf",   64'(a_ovf),   64'(m_ovf));
        chk("a_udf",   64'(a_udf),   64'(m_udf));
        chk("a_rd_valid", 64'(a_rd_valid), 64'(racc));
        if (racc) chk("a_rd_data", 64'(a_rd_data), 64'(exp_d));
    endtask

    initial begin
        rst = 1'b1;
        a_wr_en = 0; a_rd_en = 0; a_clr = 0; a_wr_data = '0;
        f_wr_en = 0; f_rd_en = 0; f_clr = 0; f_wr_data = '0;
        w_wr_en = 0; w_rd_en = 0; w_clr = 0; w_wr_data = '0;
        m_cnt = 0; m_ovf = 0; m_udf = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_empty", 64'(a_empty), 64'd1);
        chk("rst_full",  64'(a_full),  64'd0);
        chk("rst_aempty",64'(a_ae),    64'd1);
        chk("rst_afull", 64'(a_af),    64'd0);
        chk("rst_rd_valid", 64'(a_rd_valid), 64'd0);
        chk("rst_rd_data",  64'(a_rd_data),  64'd0);
        chk("rst_ovf", 64'(a_ovf), 64'd0);
        chk("rst_udf", 64'(a_udf), 64'd0);
        chk("rst_f_rd_valid", 64'(f_rd_valid), 64'd0);

        // Fall-through: written word shows up without a read request
        f_wr_en = 1; f_wr_data = 8'hA5;
        @(posedge clk); #1 f_wr_en = 0;
        chk("f_head_data",  64'(f_rd_data),  64'hA5);
        chk("f_head_valid", 64'(f_rd_valid), 64'd1);
        chk("f_count1",     64'(f_count),    64'd1);
        f_rd_en = 1;
        @(posedge clk); #1 f_rd_en = 0;
        chk("f_pop_empty", 64'(f_empty),    64'd1);
        chk("f_pop_valid", 64'(f_rd_valid), 64'd0);
        f_wr_en = 1; f_wr_data = 8'h11;
        @(posedge clk); #1 f_wr_data = 8'h22;
        @(posedge clk); #1 f_wr_en = 0;
        chk("f_head1", 64'(f_rd_data), 64'h11);
        f_rd_en = 1;
        @(posedge clk); #1 f_rd_en = 0;
        chk("f_head2", 64'(f_rd_data), 64'h22);
        chk("f_valid2", 64'(f_rd_valid), 64'd1);

        // Wide/shallow configuration
        chk("w_rst_aempty", 64'(w_ae), 64'd1);
        for (int i = 0; i < 8; i++) begin
            w_wr_en = 1; w_wr_data = 32'hDEADBEEF ^ 32'(i * 32'h01010101);
            sb_w.push_back(w_wr_data);
            @(posedge clk); #1 w_wr_en = 0;
            chk("w_full",   64'(w_full),  64'(i == 7));
            chk("w_afull",  64'(w_af),    64'(i == 7));
            chk("w_aempty", 64'(w_ae),    64'd0);
            chk("w_empty",  64'(w_empty), 64'd0);
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp_w;
            exp_w = sb_w.pop_front();
            w_rd_en = 1;
            @(posedge clk); #1 w_rd_en = 0;
            chk("w_rd_valid", 64'(w_rd_valid), 64'd1);
            chk("w_rd_data",  64'(w_rd_data),  64'(exp_w));
            chk("w_aempty_end", 64'(w_ae),    64'(i == 7));
            chk("w_empty_end",  64'(w_empty), 64'(i == 7));
            chk("w_afull_rd",   64'(w_af),    64'd0);
        end

        // Fill / drain
        for (int i = 1; i <= 16; i++) step_a(1, 8'(i), 0, 0);
        chk("t1_full",  64'(a_full),  64'd1);
        chk("t1_count", 64'(a_count), 64'd16);

        // Overflow, drain in order, underflow, clear
        step_a(1, 8'hEE, 0, 0);
        for (int i = 1; i <= 16; i++) step_a(0, 8'h00, 1, 0);
        chk("t2_empty", 64'(a_empty), 64'd1);
        step_a(0, 8'h00, 1, 0);
        chk("t2_ovf", 64'(a_ovf), 64'd1);
        chk("t2_udf", 64'(a_udf), 64'd1);
        step_a(0, 8'h00, 0, 1);
        chk("t2_clr_ovf", 64'(a_ovf), 64'd0);
        chk("t2_clr_udf", 64'(a_udf), 64'd0);

        // Simultaneous read+write at count 5, pointers wrap
        for (int i = 0; i < 5; i++) step_a(1, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 20; i++) step_a(1, 8'(8'h40 + i), 1, 0);
        chk("t3_count5", 64'(a_count), 64'd5);
        for (int i = 0; i < 11; i++) step_a(1, 8'(8'h80 + i), 0, 0);
        step_a(1, 8'hF0, 1, 0);
        chk("t3_full_both_cnt", 64'(a_count), 64'd15);
        chk("t3_full_both_ovf", 64'(a_ovf),   64'd1);
        step_a(0, 8'h00, 0, 1);
        step_a(1, 8'h9A, 0, 0);
        step_a(1, 8'h9B, 0, 1);
        chk("t2_set_wins", 64'(a_ovf), 64'd1);
        for (int i = 0; i < 16; i++) step_a(0, 8'h00, 1, 0);
        step_a(1, 8'h77, 1, 0);
        chk("t3_empty_both_cnt", 64'(a_count), 64'd1);
        chk("t3_empty_both_udf", 64'(a_udf),   64'd1);
        step_a(0, 8'h00, 1, 1);

        // Asynchronous reset mid-stream at count 9 with rd_valid high
        for (int i = 0; i < 10; i++) step_a(1, 8'(8'hC0 + i), 0, 0);
        step_a(0, 8'h00, 1, 0);
        chk("t5_pre_count", 64'(a_count), 64'd9);
        #2 rst = 1'b1;
        #1;
        chk("t5_count", 64'(a_count), 64'd0);
        chk("t5_empty", 64'(a_empty), 64'd1);
        chk("t5_rd_valid", 64'(a_rd_valid), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        m_cnt = 0; m_ovf = 0; m_udf = 0;
        sb_a.delete();
        step_a(1, 8'h3C, 0, 0);
        step_a(0, 8'h00, 1, 0);
        chk("t5_first_word", 64'(a_rd_data), 64'h3C);
        chk("t5_empty_end",  64'(a_empty),   64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
